// File: rtl/mem_access_initiator.sv
// Data-memory requester for the multi-cycle Y86 core.
// Decodes one memory-stage access, bounds-checks the word address, issues it
// on a valid/ready request channel, waits for read data and reports
// completion with done/valM/mem_error while holding busy as the stall.
module mem_access_initiator #(
    parameter int MEM_WORDS = 16384,
    parameter int ADDR_W    = 14,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [63:0]       valE,
    input  logic [63:0]       valA,
    input  logic [63:0]       valP,
    output logic              busy,
    output logic              done,
    output logic [63:0]       valM,
    output logic              mem_error,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [63:0]       req_wdata,
    input  logic              rsp_valid,
    input  logic [63:0]       rsp_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    logic             dec_rd;
    logic             dec_wr;
    logic [63:0]      dec_addr;
    logic [63:0]      dec_wdata;
    logic             addr_bad;

    // Decode the instruction into read/write, address source and store data
    always_comb begin
        dec_rd    = 1'b0;
        dec_wr    = 1'b0;
        dec_addr  = valE;
        dec_wdata = valA;
        case (icode)
            4'h5:       dec_rd = 1'b1;
            4'h9, 4'hB: begin
                dec_rd   = 1'b1;
                dec_addr = valA;
            end
            4'h4, 4'hA: dec_wr = 1'b1;
            4'h8: begin
                dec_wr    = 1'b1;
                dec_wdata = valP;
            end
            default: ;
        endcase
        addr_bad = (dec_addr >= 64'(MEM_WORDS));
        cnt_last = (cnt == CNT_W'(TIMEOUT - 1));
    end

    // Access sequencer: all outputs are registered alongside the state.
    // DONE shows busy=0, so a start arriving there is accepted like in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_error <= 1'b0;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            valM      <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start) begin
                        if ((dec_rd || dec_wr) && !addr_bad) begin
                            req_valid <= 1'b1;
                            req_we    <= dec_wr;
                            req_addr  <= dec_addr[ADDR_W-1:0];
                            req_wdata <= dec_wdata;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            state     <= S_REQ;
                        end else begin
                            done      <= 1'b1;
                            mem_error <= (dec_rd || dec_wr) && addr_bad;
                            state     <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        if (req_we) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            mem_error <= 1'b0;
                            state     <= S_DONE;
                        end else begin
                            cnt   <= '0;
                            state <= S_WAIT_RSP;
                        end
                    end else if (cnt_last) begin
                        req_valid <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        mem_error <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_RSP: begin
                    if (rsp_valid) begin
                        valM      <= rsp_rdata;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        mem_error <= 1'b0;
                        state     <= S_DONE;
                    end else if (cnt_last) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        mem_error <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Testbench for mem_access_initiator: directed scenarios plus randomized
// accesses checked against a latency/result reference model.
module tb_mem_access_initiator;

    localparam int MW = 16384;
    localparam int AW = 14;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    icode;
    logic [63:0]   valE, valA, valP;
    logic          busy, done, mem_error;
    logic [63:0]   valM;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic          rsp_valid;
    logic [63:0]   rsp_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_access_initiator #(.MEM_WORDS(MW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP),
        .busy(busy), .done(done), .valM(valM), .mem_error(mem_error),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    typedef struct {
        bit            req;
        bit            we;
        logic [AW-1:0] addr;
        logic [63:0]   wdata;
        int            done_c;
        bit            err;
        logic [63:0]   valm;
    } exp_t;

    typedef struct {
        bit            req;
        bit            we;
        logic [AW-1:0] addr;
        logic [63:0]   wdata;
        bit            stable;
        bit            valid_after;
        bit            busy_ok;
        int            done_c;
        bit            err;
        logic [63:0]   valm;
        bit            busy_at_done;
        bit            done_after;
        bit            busy_after;
    } obs_t;

    // Architectural valM the model believes the DUT currently holds
    logic [63:0] model_valm;

    // Reference: decode plus completion cycle counted from the start cycle (0)
    function automatic exp_t model(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                                   input logic [63:0] p, input int rdy_d, input int rsp_d,
                                   input logic [63:0] data);
        exp_t x;
        bit rd, wr;
        logic [63:0] addr;
        int hs;
        rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        addr = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
        x.req = 1'b0;
        x.we = wr;
        x.addr = addr[AW-1:0];
        x.wdata = (ic == 4'h8) ? p : a;
        x.err = 1'b0;
        x.valm = model_valm;
        if (!(rd || wr)) begin
            x.done_c = 1;
        end else if (addr >= 64'(MW)) begin
            x.done_c = 1;
            x.err = 1'b1;
        end else begin
            x.req = 1'b1;
            if (rdy_d >= TO) begin
                x.done_c = 1 + TO;
                x.err = 1'b1;
            end else begin
                hs = 1 + rdy_d;
                if (wr) x.done_c = hs + 1;
                else if (rsp_d >= TO) begin
                    x.done_c = hs + 1 + TO;
                    x.err = 1'b1;
                end else begin
                    x.done_c = hs + 2 + rsp_d;
                    x.valm = data;
                end
            end
        end
        return x;
    endfunction

    // Drives one access and acts as the responder; records what the DUT did
    task automatic run_access(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                              input logic [63:0] p, input int rdy_d, input int rsp_d,
                              input logic [63:0] data, input bit noise, input bit junk_rsp,
                              output obs_t o);
        int first_c, hs_c;
        bit hs;
        o = '{default: 0};
        o.stable = 1'b1;
        o.busy_ok = 1'b1;
        o.done_c = -1;
        first_c = -1;
        hs = 1'b0;
        hs_c = 0;
        @(negedge clk);
        icode = ic; valE = e; valA = a; valP = p;
        start = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0;
        for (int cyc = 1; cyc <= 4 * TO + 10; cyc++) begin
            @(negedge clk);
            if (done) begin
                o.done_c = cyc;
                o.err = mem_error;
                o.valm = valM;
                o.busy_at_done = busy;
                break;
            end
            if (!busy) o.busy_ok = 1'b0;
            if (hs && req_valid) o.valid_after = 1'b1;
            if (req_valid && !hs) begin
                if (!o.req) begin
                    o.req = 1'b1; first_c = cyc;
                    o.we = req_we; o.addr = req_addr; o.wdata = req_wdata;
                end else if (req_we !== o.we || req_addr !== o.addr || req_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
            end
            rsp_valid = (hs && !o.we && cyc == hs_c + 1 + rsp_d) || (junk_rsp && !hs);
            rsp_rdata = hs ? data : ~data;
            req_ready = req_valid && !hs && (cyc - first_c >= rdy_d);
            if (req_ready) begin
                hs = 1'b1;
                hs_c = cyc;
            end
            start = noise && busy;
            if (noise) begin
                icode = 4'($urandom);
                valE = {$urandom, $urandom};
                valA = {$urandom, $urandom};
                valP = {$urandom, $urandom};
            end
        end
        start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        @(negedge clk);
        o.done_after = done;
        o.busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; icode = '0; valE = '0; valA = '0; valP = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, mem_error, req_valid, req_we} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, mem_error, req_valid, req_we});
        end
        tests_run++;
        if (valM !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_valM: got %0h expected 0", valM);
        end
        tests_run++;
        if (req_addr !== '0 || req_wdata !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_req_fields: got addr %0h wdata %0h expected 0 0", req_addr, req_wdata);
        end
        rst = 1'b0;
        model_valm = '0;
        @(negedge clk);
    endtask

    task automatic test_mrmovq();
        obs_t o;
        run_access(4'h5, 64'h10, 64'h0, 64'h0, 0, 0, 64'hDEAD_BEEF, 1'b0, 1'b0, o);
        tests_run++;
        if (!o.req || o.we !== 1'b0 || o.addr !== 14'h10) begin
            tests_failed++;
            $display("FAIL mrmovq_req: got req %0d we %0d addr %0h expected 1 0 10", o.req, o.we, o.addr);
        end
        tests_run++;
        if (o.done_c !== 3 || o.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mrmovq_done: got cycle %0d err %0d expected 3 0", o.done_c, o.err);
        end
        tests_run++;
        if (o.valm !== 64'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL mrmovq_valM: got %0h expected deadbeef", o.valm);
        end
        model_valm = 64'hDEAD_BEEF;
    endtask

    task automatic test_pushq_stall();
        obs_t o;
        run_access(4'hA, 64'h3FF8, 64'h55, 64'h0, 4, 0, 64'h0, 1'b1, 1'b0, o);
        tests_run++;
        if (!o.req || o.we !== 1'b1 || o.addr !== 14'h3FF8 || o.wdata !== 64'h55 || !o.stable) begin
            tests_failed++;
            $display("FAIL pushq_req: got req %0d we %0d addr %0h wdata %0h stable %0d expected 1 1 3ff8 55 1",
                     o.req, o.we, o.addr, o.wdata, o.stable);
        end
        tests_run++;
        if (o.done_c !== 6 || o.err !== 1'b0 || !o.busy_ok) begin
            tests_failed++;
            $display("FAIL pushq_done: got cycle %0d err %0d busy_ok %0d expected 6 0 1", o.done_c, o.err, o.busy_ok);
        end
        tests_run++;
        if (o.valm !== 64'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL pushq_valM_hold: got %0h expected deadbeef", o.valm);
        end
    endtask

    task automatic test_call_popq();
        obs_t o;
        run_access(4'h8, 64'h20, 64'h777, 64'h123, 0, 0, 64'h0, 1'b0, 1'b0, o);
        tests_run++;
        if (o.we !== 1'b1 || o.wdata !== 64'h123 || o.addr !== 14'h20 || o.done_c !== 2) begin
            tests_failed++;
            $display("FAIL call_req: got we %0d wdata %0h addr %0h cycle %0d expected 1 123 20 2",
                     o.we, o.wdata, o.addr, o.done_c);
        end
        run_access(4'hB, 64'h3000, 64'h20, 64'h0, 1, 2, 64'h123, 1'b0, 1'b0, o);
        tests_run++;
        if (!o.req || o.we !== 1'b0 || o.addr !== 14'h20 || o.valid_after) begin
            tests_failed++;
            $display("FAIL popq_req: got req %0d we %0d addr %0h valid_after %0d expected 1 0 20 0",
                     o.req, o.we, o.addr, o.valid_after);
        end
        tests_run++;
        if (o.valm !== 64'h123 || o.done_c !== 6) begin
            tests_failed++;
            $display("FAIL popq_done: got valM %0h cycle %0d expected 123 6", o.valm, o.done_c);
        end
        model_valm = 64'h123;
    endtask

    task automatic test_bad_addr();
        obs_t o;
        run_access(4'h4, 64'd16384, 64'h9, 64'h0, 0, 0, 64'h0, 1'b0, 1'b0, o);
        tests_run++;
        if (o.req || o.done_c !== 1 || o.err !== 1'b1 || o.busy_at_done) begin
            tests_failed++;
            $display("FAIL bad_16384: got req %0d cycle %0d err %0d expected 0 1 1", o.req, o.done_c, o.err);
        end
        run_access(4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'h9, 64'h0, 0, 0, 64'h0, 1'b0, 1'b0, o);
        tests_run++;
        if (o.req || o.done_c !== 1 || o.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_neg8: got req %0d cycle %0d err %0d expected 0 1 1", o.req, o.done_c, o.err);
        end
        run_access(4'h6, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 0, 0, 64'h0, 1'b0, 1'b0, o);
        tests_run++;
        if (o.req || o.done_c !== 1 || o.err !== 1'b0 || o.valm !== model_valm) begin
            tests_failed++;
            $display("FAIL noop: got req %0d cycle %0d err %0d valM %0h expected 0 1 0 %0h",
                     o.req, o.done_c, o.err, o.valm, model_valm);
        end
        run_access(4'h4, 64'd16383, 64'hAB, 64'h0, 0, 0, 64'h0, 1'b0, 1'b0, o);
        tests_run++;
        if (!o.req || o.addr !== 14'h3FFF || o.done_c !== 2 || o.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL last_word: got req %0d addr %0h cycle %0d err %0d expected 1 3fff 2 0",
                     o.req, o.addr, o.done_c, o.err);
        end
        run_access(4'h5, 64'h40, 64'h0, 64'h0, 0, 1, 64'h5A5A, 1'b0, 1'b1, o);
        tests_run++;
        if (o.valm !== 64'h5A5A || o.done_c !== 4) begin
            tests_failed++;
            $display("FAIL early_rsp_ignored: got valM %0h cycle %0d expected 5a5a 4", o.valm, o.done_c);
        end
        model_valm = 64'h5A5A;
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(4'h5, 64'h100, 64'h0, 64'h0, 0, 1000, 64'h1111, 1'b0, 1'b0, o);
        tests_run++;
        if (o.done_c !== 2 + TO || o.err !== 1'b1 || o.valm !== 64'h5A5A || o.busy_after) begin
            tests_failed++;
            $display("FAIL rsp_timeout: got cycle %0d err %0d valM %0h busy %0d expected %0d 1 5a5a 0",
                     o.done_c, o.err, o.valm, o.busy_after, 2 + TO);
        end
        run_access(4'h5, 64'h100, 64'h0, 64'h0, 0, TO - 1, 64'h2222, 1'b0, 1'b0, o);
        tests_run++;
        if (o.done_c !== TO + 2 || o.err !== 1'b0 || o.valm !== 64'h2222) begin
            tests_failed++;
            $display("FAIL rsp_last_cycle: got cycle %0d err %0d valM %0h expected %0d 0 2222",
                     o.done_c, o.err, o.valm, TO + 2);
        end
        model_valm = 64'h2222;
        run_access(4'h4, 64'h100, 64'h3, 64'h0, TO, 0, 64'h0, 1'b0, 1'b0, o);
        tests_run++;
        if (o.done_c !== 1 + TO || o.err !== 1'b1 || o.done_after || o.busy_after) begin
            tests_failed++;
            $display("FAIL req_timeout: got cycle %0d err %0d done_after %0d expected %0d 1 0",
                     o.done_c, o.err, o.done_after, 1 + TO);
        end
        run_access(4'h4, 64'h100, 64'h3, 64'h0, TO - 1, 0, 64'h0, 1'b0, 1'b0, o);
        tests_run++;
        if (o.done_c !== TO + 1 || o.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL req_last_cycle: got cycle %0d err %0d expected %0d 0", o.done_c, o.err, TO + 1);
        end
    endtask

    task automatic test_reset_midflight();
        obs_t o;
        @(negedge clk);
        icode = 4'h4; valE = 64'h40; valA = 64'h7; start = 1'b1; req_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_valid !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_req: got valid %0d busy %0d expected 1 1", req_valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (req_valid !== 1'b0 || busy !== 1'b0 || valM !== 64'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got valid %0d busy %0d valM %0h expected 0 0 0", req_valid, busy, valM);
        end
        @(negedge clk);
        rst = 1'b0;
        model_valm = '0;
        run_access(4'h9, 64'h0, 64'h88, 64'h0, 0, 0, 64'hCAFE, 1'b0, 1'b0, o);
        tests_run++;
        if (o.done_c !== 3 || o.err !== 1'b0 || o.valm !== 64'hCAFE || o.addr !== 14'h88) begin
            tests_failed++;
            $display("FAIL after_reset_read: got cycle %0d err %0d valM %0h addr %0h expected 3 0 cafe 88",
                     o.done_c, o.err, o.valm, o.addr);
        end
        model_valm = 64'hCAFE;
    endtask

    task automatic test_random();
        obs_t o;
        exp_t x;
        logic [3:0] ic;
        logic [63:0] e, a, p, d;
        int rdy_d, rsp_d, sel;
        for (int i = 0; i < 80; i++) begin
            ic = 4'($urandom);
            e = 64'($urandom_range(MW - 1, 0));
            a = 64'($urandom_range(MW - 1, 0));
            p = {$urandom, $urandom};
            d = {$urandom, $urandom};
            sel = $urandom_range(9, 0);
            if (sel == 0) e = {$urandom | 32'h1, $urandom};
            if (sel == 1) a = 64'(MW) + 64'($urandom_range(100, 0));
            if (sel == 2) e = 64'(MW - 1);
            rdy_d = $urandom_range(3, 0);
            rsp_d = $urandom_range(3, 0);
            if ($urandom_range(7, 0) == 0) rdy_d = TO - 1 + $urandom_range(1, 0);
            if ($urandom_range(7, 0) == 0) rsp_d = TO - 1 + $urandom_range(1, 0);
            x = model(ic, e, a, p, rdy_d, rsp_d, d);
            run_access(ic, e, a, p, rdy_d, rsp_d, d, $urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0, o);
            tests_run++;
            if (o.req !== x.req || (x.req && (o.we !== x.we || o.addr !== x.addr || (x.we && o.wdata !== x.wdata)))) begin
                tests_failed++;
                $display("FAIL rand%0d_req: got req %0d we %0d addr %0h wdata %0h expected %0d %0d %0h %0h",
                         i, o.req, o.we, o.addr, o.wdata, x.req, x.we, x.addr, x.wdata);
            end
            tests_run++;
            if (o.done_c !== x.done_c || o.err !== x.err || o.valm !== x.valm) begin
                tests_failed++;
                $display("FAIL rand%0d_done: got cycle %0d err %0d valM %0h expected %0d %0d %0h",
                         i, o.done_c, o.err, o.valm, x.done_c, x.err, x.valm);
            end
            tests_run++;
            if (!o.stable || o.valid_after || !o.busy_ok || o.busy_at_done || o.done_after || o.busy_after) begin
                tests_failed++;
                $display("FAIL rand%0d_handshake: got stable %0d valid_after %0d busy_ok %0d busy_done %0d done_after %0d busy_after %0d expected 1 0 1 0 0 0",
                         i, o.stable, o.valid_after, o.busy_ok, o.busy_at_done, o.done_after, o.busy_after);
            end
            model_valm = x.valm;
        end
    endtask

    initial begin
        test_reset();
        test_mrmovq();
        test_pushq_stall();
        test_call_popq();
        test_bad_addr();
        test_timeout();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
